arm_mc_sequencer: RTL
=====================

// Module: arm_mc_sequencer
// PURPOSE
//  Main-control FSM for the multicycle ARM core. Supports the DP (ADD/SUB/AND/ORR/EOR/MOV/CMP/TST),
//  LDR/LDRB/STR and B instructions. It sequences the shared ALU and the unified instr/data memory
//  over several cycles per instruction. It issues unconditional strobes; condlogic still gates RegW/MemW/PCS by CondEx.
//  Memory accesses use a ready handshake. A bounded wait timer traps a hung memory.
// PARAMETERS
//  MAX_WAIT  15  max consecutive MemReady=0 cycles tolerated in one access state; range 1..255
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  Op         in   2      Instr[27:26], sampled from IR in DECODE
//  Funct      in   6      Instr[25:20]: [5]=I, [0]=S/L
//  MemReady   in   1      memory accepted (write) or returned data (read) this cycle
//  IRWrite    out  1      load instruction register
//  AdrSrc     out  1      0=PC, 1=ALUOut drives memory address
//  ALUSrcA    out  2      00=A(Rn), 01=PC, others reserved (drive 00)
//  ALUSrcB    out  2      00=WriteData(Rm), 01=ExtImm, 10=const 4
//  ResultSrc  out  2      00=ALUOut, 01=Data reg, 10=ALUResult
//  NextPC     out  1      PC write enable (fetch increment)
//  RegW       out  1      register write request (pre-condition)
//  MemW       out  1      memory write request (pre-condition)
//  Branch     out  1      branch request (pre-condition)
//  ALUOp      out  1      1 = ALU decoder uses Funct; 0 = ADD
//  InstrDone  out  1      1-cycle pulse in final state of every retired instruction
//  Illegal    out  1      1-cycle pulse when Op=11 is decoded
//  BusErr     out  1      sticky fault flag
//  InstRet    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH DECODE MEMADR MEMRD MEMWB MEMWR EXECR EXECI ALUWB BRANCH ILLEGAL FAULT.
//  Moore outputs. Exceptions: IRWrite/NextPC in FETCH and InstrDone in MEMWR are qualified by MemReady.
//  Unlisted outputs are 0. Selects are never x.
//  FETCH  : AdrSrc=0 ALUSrcA=01 ALUSrcB=10 ResultSrc=10. On MemReady: IRWrite=NextPC=1 -> DECODE. Else hold.
//  DECODE : ALUSrcA=01 ALUSrcB=10 ResultSrc=10 (PC+8 for R15).
//           Op 01->MEMADR; 00 & Funct[5]->EXECI; 00 & ~Funct[5]->EXECR; 10->BRANCH; 11->ILLEGAL.
//  MEMADR : ALUSrcA=00 ALUSrcB=01 ALUOp=0. Funct[0] ? MEMRD : MEMWR.
//  MEMRD  : AdrSrc=1. MemReady -> MEMWB. Else hold.
//  MEMWB  : ResultSrc=01 RegW=1 InstrDone=1 -> FETCH.
//  MEMWR  : AdrSrc=1 MemW=1, held stable while waiting. MemReady -> FETCH with InstrDone=1.
//  EXECR  : ALUSrcA=00 ALUSrcB=00 ALUOp=1 -> ALUWB.   EXECI : as EXECR but ALUSrcB=01.
//  ALUWB  : ResultSrc=00 RegW=1 InstrDone=1 -> FETCH (condlogic suppresses RegW for CMP/TST).
//  BRANCH : ALUSrcA=00 ALUSrcB=01 ResultSrc=10 Branch=1 InstrDone=1 -> FETCH.
//  ILLEGAL: Illegal=1, no strobes, no InstrDone -> FETCH (PC already advanced).
//  Latency (zero-wait memory): DP 4, STR 4, LDR 5, B 3 cycles.
//  Each memory wait cycle adds 1 cycle to the instruction.
//  Wait timer: cleared on entry to FETCH/MEMRD/MEMWR and on any MemReady=1.
//    It increments per cycle in those states while MemReady=0.
//    If the counter equals MAX_WAIT and MemReady=0, go to FAULT next.
//  FAULT  : all strobes 0, BusErr=1, absorbing until reset. MemReady is ignored.
//  InstRet: +1 per InstrDone, wraps modulo 2^CNT_W.
//    A MemReady that arrives in the same cycle the timer reaches MAX_WAIT wins (no fault).
//  Reset (sync): while reset=1, all strobes, InstrDone, Illegal are forced to 0.
//    Next state is FETCH. Timer=0, InstRet=0, BusErr=0.
//    Mid-instruction reset abandons the instruction: no RegW/MemW, no count.
// STRUCTURE
//  arm_mc_pkg: state_t enum (4-bit); localparams for ALUSrcA/ALUSrcB/ResultSrc/AdrSrc codes; OP_DP/OP_MEM/OP_BR.
//  Sub-module mc_wait_timer (clk, reset, clr, en, expired), width $clog2(MAX_WAIT+1).
//  Sequencer = state reg + next-state comb + output comb + InstRet counter.
// TESTING
//  1 ADD imm, MemReady=1 always: FETCH,DECODE,EXECI,ALUWB; RegW=1 only in ALUWB; InstrDone at cycle 4; InstRet=1.
//  2 LDR with MemReady low 3 cycles in MEMRD: AdrSrc=1 held 4 cycles, then MEMWB with ResultSrc=01; 8 cycles total.
//  3 STR, MemReady low 2 cycles in MEMWR: MemW=1 for 3 consecutive cycles, InstrDone only with MemReady.
//  4 MAX_WAIT=3, MemReady stuck 0 in FETCH: FAULT after 4 cycles, BusErr=1 sticky.
//    Reset -> FETCH, BusErr=0. Also: MemReady=1 on 4th cycle -> no fault.
//  5 Op=11 then B: Illegal pulses once, InstRet unchanged. Then B: Branch=1 in cycle 3, InstRet+1.
//  6 Reset asserted in MEMWR with MemW=1: MemW=0 same cycle, FETCH next, InstRet=0.
//    CNT_W=4 run of 17 instrs -> InstRet=1.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared types and select encodings for the multicycle ARM main-control sequencer.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10,
    S_FAULT   = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_RN    = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // States that sit on the memory handshake and are covered by the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/arm_mc_sequencer_if.sv
// Control bundle between the main-control sequencer (master) and the multicycle datapath (slave).
interface arm_mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             MemReady;
  logic             IRWrite;
  logic             AdrSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic             NextPC;
  logic             RegW;
  logic             MemW;
  logic             Branch;
  logic             ALUOp;
  logic             InstrDone;
  logic             Illegal;
  logic             BusErr;
  logic [CNT_W-1:0] InstRet;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
           Branch, ALUOp, InstrDone, Illegal, BusErr, InstRet
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
           Branch, ALUOp, InstrDone, Illegal, BusErr, InstRet
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory-wait cycles; expired flags that the tolerated limit has been reached.
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == W'(MAX_WAIT));

endmodule

// File: rtl/arm_mc_sequencer.sv
// Main-control FSM for the multicycle ARM core: sequences ALU and unified memory per instruction.
//
//  state   | meaning
//  FETCH   | read instruction at PC, PC+4 on MemReady
//  DECODE  | read registers, ALU forms PC+8
//  MEMADR  | compute load/store address
//  MEMRD   | wait for read data
//  MEMWB   | write loaded data to register file
//  MEMWR   | present store until memory accepts
//  EXECR   | DP with register operand
//  EXECI   | DP with immediate operand
//  ALUWB   | write ALU result
//  BRANCH  | compute and take branch target
//  ILLEGAL | report Op=11, retire nothing
//  FAULT   | memory hung, absorbing until reset
module arm_mc_sequencer
  import arm_mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  arm_mc_sequencer_if.master  bus
);

  state_t           state, state_n;
  logic             tmr_clr, tmr_en, tmr_expired;
  logic [CNT_W-1:0] inst_ret;
  logic             unused_funct;

  assign unused_funct = ^bus.Funct[4:1];

  assign tmr_en  = is_wait_state(state) && !bus.MemReady;
  assign tmr_clr = bus.MemReady || (state_n != state);

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:   if (bus.MemReady) state_n = S_DECODE;
                 else if (tmr_expired) state_n = S_FAULT;
      S_DECODE:  case (bus.Op)
                   OP_MEM:  state_n = S_MEMADR;
                   OP_DP:   state_n = bus.Funct[5] ? S_EXECI : S_EXECR;
                   OP_BR:   state_n = S_BRANCH;
                   default: state_n = S_ILLEGAL;
                 endcase
      S_MEMADR:  state_n = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.MemReady) state_n = S_MEMWB;
                 else if (tmr_expired) state_n = S_FAULT;
      S_MEMWR:   if (bus.MemReady) state_n = S_FETCH;
                 else if (tmr_expired) state_n = S_FAULT;
      S_EXECR,
      S_EXECI:   state_n = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_ILLEGAL: state_n = S_FETCH;
      S_FAULT:   state_n = S_FAULT;
      default:   state_n = S_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held so an abandoned instruction never commits.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = ADR_PC;
    bus.ALUSrcA   = SRCA_RN;
    bus.ALUSrcB   = SRCB_RM;
    bus.ResultSrc = RES_ALUOUT;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    bus.BusErr    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.AdrSrc    = ADR_PC;
          bus.ALUSrcA   = SRCA_PC;
          bus.ALUSrcB   = SRCB_FOUR;
          bus.ResultSrc = RES_ALURES;
          bus.IRWrite   = bus.MemReady;
          bus.NextPC    = bus.MemReady;
        end
        S_DECODE: begin
          bus.ALUSrcA   = SRCA_PC;
          bus.ALUSrcB   = SRCB_FOUR;
          bus.ResultSrc = RES_ALURES;
        end
        S_MEMADR: begin
          bus.ALUSrcA = SRCA_RN;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_MEMRD:  bus.AdrSrc = ADR_ALUOUT;
        S_MEMWB: begin
          bus.ResultSrc = RES_DATA;
          bus.RegW      = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_MEMWR: begin
          bus.AdrSrc    = ADR_ALUOUT;
          bus.MemW      = 1'b1;
          bus.InstrDone = bus.MemReady;
        end
        S_EXECR: begin
          bus.ALUSrcB = SRCB_RM;
          bus.ALUOp   = 1'b1;
        end
        S_EXECI: begin
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = 1'b1;
        end
        S_ALUWB: begin
          bus.ResultSrc = RES_ALUOUT;
          bus.RegW      = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcB   = SRCB_IMM;
          bus.ResultSrc = RES_ALURES;
          bus.Branch    = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_ILLEGAL: bus.Illegal = 1'b1;
        S_FAULT:   bus.BusErr  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_ret <= '0;
    end else if (bus.InstrDone) begin
      inst_ret <= inst_ret + CNT_W'(1);
    end
  end

  assign bus.InstRet = inst_ret;

endmodule
